input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter: DB_LIMIT, default 50000, number of consecutive clock cycles a synchronized key must differ from its debounced state before that state changes; legal range 2..65535.
REQ-002 Clk  input  1  system clock, all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset (asserted when 0, sampled on Clk rising edge).
REQ-004 Run_Key  input  1  raw Run pushbutton, asynchronous, active-low (0 = pressed).
REQ-005 Clr_Key  input  1  raw Reset_Load_Clear pushbutton, asynchronous, active-low.
REQ-006 SW  input  8  raw slide switches, asynchronous.
REQ-007 Run_Pulse  output  1  active-high, exactly one Clk cycle per accepted Run press; feeds the multiplier control Run input.
REQ-008 Clr_Level  output  1  active-high debounced Clear/Load level; feeds the multiplier control ClearA_LoadB/Reset input.
REQ-009 Run_Level  output  1  active-high debounced Run level, for LED/debug.
REQ-010 SW_S  output  8  synchronized switch value; feeds the multiplier B-load and adder operand.

Function
REQ-011 Each key SHALL pass through a two-flop synchronizer (s1 <= raw, s2 <= s1); pressed_sync = ~s2.
REQ-012 Per key, a 16-bit counter and a stable bit: if pressed_sync == stable, counter <= 0; else if counter == DB_LIMIT-1, stable <= pressed_sync and counter <= 0; else counter <= counter+1.
REQ-013 Clean press latency: raw falls before edge 1 -> stable rises at edge 2+DB_LIMIT; release symmetric.
REQ-014 Any glitch shorter than DB_LIMIT cycles at s2 SHALL restart the count and SHALL NOT change stable.
REQ-015 Run_Level = Run stable bit; Clr_Level = Clr stable bit (registered, no extra delay).
REQ-016 Run_Pulse SHALL be registered: high in the cycle after Run stable rises 0->1, for one cycle only; held press produces no further pulses.
REQ-017 Priority: Run_Pulse SHALL be suppressed if Clr stable is 1 in the cycle the Run rising edge is detected; no deferred pulse after Clr releases.
REQ-018 Run release (stable 1->0) SHALL produce no pulse.
REQ-019 SW_S SHALL be a per-bit two-flop synchronizer of SW, no debounce; latency 2 edges.
REQ-020 Counter SHALL never exceed DB_LIMIT-1; no wrap-around.

Reset
REQ-021 While Reset = 0 at a Clk edge: s1/s2 of both keys <= 1 (idle), counters <= 0, stable bits <= 0, Run_Pulse <= 0, SW_S flops <= 0.
REQ-022 Reset mid-count SHALL discard partial count; a key held through reset release SHALL be accepted DB_LIMIT+2 edges after release, producing one Run_Pulse (unless Clr stable).
REQ-023 All outputs SHALL be 0 in the first cycle after reset.

Structure
REQ-024 Shared package input_cond_pkg SHALL hold DB_CNT_W = 16 and DB_LIMIT_DEFAULT = 50000.
REQ-025 Sub-module debounce_key (synchronizer + counter + stable bit, DB_LIMIT parameter) SHALL be instantiated twice (Run, Clr); edge detect, priority and SW sync live in the top.
REQ-026 Target 120-200 lines RTL total; no latches, no combinational outputs.

Verification (DB_LIMIT = 4)
REQ-027 Reset low 2 cycles, then Run_Key 1->0 before edge 1, held 20 cycles -> Run_Level rises at edge 6, Run_Pulse high only in cycle after edge 7, then 0.
REQ-028 Run_Key low for 3 cycles then high (bounce) -> Run_Level and Run_Pulse stay 0.
REQ-029 Clr_Key held low, then Run_Key pressed after Clr_Level = 1 -> Clr_Level 1, Run_Level 1, Run_Pulse never asserted; release Clr -> still no pulse.
REQ-030 Run_Key low, Reset asserted at edge 4 for one cycle, key held -> no pulse before reset; single Run_Pulse at 7th edge after reset release.
REQ-031 SW 0x00 -> 0xA5 before edge 1 -> SW_S = 0xA5 from edge 2 on; Reset -> SW_S = 0x00.
REQ-032 Press/release Run 3 times, each 10 cycles low/10 high -> exactly 3 Run_Pulse cycles, none on release.

Source files
------------

// File: rtl/input_cond_pkg.sv
// ============================================================
// input_cond_pkg : shared constants for the input conditioner
// Rev 1.0
// ============================================================
`default_nettype none

package input_cond_pkg;
  localparam int unsigned DB_CNT_W         = 16;
  localparam int unsigned DB_LIMIT_DEFAULT = 50000;
endpackage

`default_nettype wire

// File: rtl/debounce_key.sv
// ============================================================
// debounce_key : two-flop synchronizer plus counter debounce
// Rev 1.0
// ============================================================
`default_nettype none

module debounce_key
  import input_cond_pkg::*;
#(
  parameter int unsigned DB_LIMIT = DB_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic stable
);

  localparam logic [DB_CNT_W-1:0] LIMIT_M1 = DB_CNT_W'(DB_LIMIT - 1);

  logic                s1;
  logic                s2;
  logic                pressed_sync;
  logic [DB_CNT_W-1:0] cnt;

  assign pressed_sync = ~s2;

  // Any disagreement shorter than DB_LIMIT cycles restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      if (pressed_sync == stable) begin
        cnt <= '0;
      end else if (cnt == LIMIT_M1) begin
        stable <= pressed_sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================
// input_conditioner : debounced keys, Run pulse, switch sync
// Rev 1.0
// ============================================================
`default_nettype none

module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned DB_LIMIT = DB_LIMIT_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_Key,
  input  logic       Clr_Key,
  input  logic [7:0] SW,
  output logic       Run_Pulse,
  output logic       Clr_Level,
  output logic       Run_Level,
  output logic [7:0] SW_S
);

  logic       run_stable;
  logic       clr_stable;
  logic       run_prev;
  logic [7:0] sw_s1;

  debounce_key #(.DB_LIMIT(DB_LIMIT)) u_run (
    .clk    (Clk),
    .rst_n  (Reset),
    .key_n  (Run_Key),
    .stable (run_stable)
  );

  debounce_key #(.DB_LIMIT(DB_LIMIT)) u_clr (
    .clk    (Clk),
    .rst_n  (Reset),
    .key_n  (Clr_Key),
    .stable (clr_stable)
  );

  assign Run_Level = run_stable;
  assign Clr_Level = clr_stable;

  // A Run press seen while Clear is held is dropped, not deferred.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      run_prev  <= 1'b0;
      Run_Pulse <= 1'b0;
      sw_s1     <= 8'h00;
      SW_S      <= 8'h00;
    end else begin
      run_prev  <= run_stable;
      Run_Pulse <= run_stable & ~run_prev & ~clr_stable;
      sw_s1     <= SW;
      SW_S      <= sw_s1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ============================================================
// tb_input_conditioner : directed vector bench, DB_LIMIT = 4
// Rev 1.0
// ============================================================
`default_nettype none

module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_n = 1'b1;
  logic       clr_n = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       run_pulse;
  logic       clr_level;
  logic       run_level;
  logic [7:0] sw_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_conditioner #(.DB_LIMIT(4)) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .Run_Key   (run_n),
    .Clr_Key   (clr_n),
    .SW        (sw),
    .Run_Pulse (run_pulse),
    .Clr_Level (clr_level),
    .Run_Level (run_level),
    .SW_S      (sw_s)
  );

  // exp = {Run_Pulse, Clr_Level, Run_Level, SW_S}
  typedef struct {
    logic        rst_n;
    logic        run_n;
    logic        clr_n;
    logic [7:0]  sw;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic rn, logic cn, logic [7:0] s,
                              logic p, logic cl, logic rl, logic [7:0] ss);
    vec_t v;
    v.rst_n = r;
    v.run_n = rn;
    v.clr_n = cn;
    v.sw    = s;
    v.exp   = {p, cl, rl, ss};
    return v;
  endfunction

  task automatic step(input logic r, input logic rn, input logic cn, input logic [7:0] s);
    @(negedge clk);
    rst_n = r;
    run_n = rn;
    clr_n = cn;
    sw    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
  endtask

  initial begin
    int pulses;
    int pulse_at;

    // Reset, clean press/release, SW sync
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'hA5, 0, 0, 0, 8'h00));      // edge 1
    for (int i = 2; i <= 5; i++) tbl.push_back(mk(1, 0, 1, 8'hA5, 0, 0, 0, 8'hA5));
    tbl.push_back(mk(1, 0, 1, 8'hA5, 0, 0, 1, 8'hA5));      // edge 6
    tbl.push_back(mk(1, 0, 1, 8'hA5, 1, 0, 1, 8'hA5));      // edge 7
    tbl.push_back(mk(1, 0, 1, 8'hA5, 0, 0, 1, 8'hA5));      // edge 8
    for (int i = 9; i <= 13; i++) tbl.push_back(mk(1, 1, 1, 8'hA5, 0, 0, 1, 8'hA5));
    tbl.push_back(mk(1, 1, 1, 8'hA5, 0, 0, 0, 8'hA5));      // edge 14
    tbl.push_back(mk(1, 1, 1, 8'hA5, 0, 0, 0, 8'hA5));
    // 3-cycle bounce must be ignored
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 1, 8'hA5, 0, 0, 0, 8'hA5));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 1, 1, 8'hA5, 0, 0, 0, 8'hA5));
    // Reset clears SW_S, then a new value takes two edges
    tbl.push_back(mk(0, 1, 1, 8'hA5, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 1, 8'h3C, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 1, 8'h3C, 0, 0, 0, 8'h3C));

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].run_n, tbl[i].clr_n, tbl[i].sw);
      check($sformatf("vec%0d", i), int'({run_pulse, clr_level, run_level, sw_s}),
            int'(tbl[i].exp));
    end

    // Clear held blocks Run pulse, and no deferred pulse after release
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    check("clr_level_held", int'(clr_level), 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      pulses += int'(run_pulse);
    end
    check("run_level_with_clr", int'(run_level), 1);
    check("pulses_with_clr", pulses, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      pulses += int'(run_pulse);
    end
    check("pulses_after_clr_release", pulses, 0);
    check("clr_level_released", int'(clr_level), 0);
    check("run_level_still_held", int'(run_level), 1);

    // Reset mid-count: partial count discarded, one pulse at 7th edge after release
    do_reset();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      pulses += int'(run_pulse);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("pulses_before_reset", pulses, 0);
    check("outputs_in_reset", int'({run_pulse, clr_level, run_level, sw_s}), 0);
    pulses   = 0;
    pulse_at = -1;
    for (int e = 1; e <= 12; e++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      if (run_pulse) begin
        pulses++;
        pulse_at = e;
      end
    end
    check("pulses_after_reset", pulses, 1);
    check("pulse_edge_after_reset", pulse_at, 7);

    // Three press/release cycles: three pulses, none on release
    do_reset();
    pulses = 0;
    pulse_at = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 1'b0, 1'b1, 8'h00);
        pulses += int'(run_pulse);
      end
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 1'b1, 1'b1, 8'h00);
        pulse_at += int'(run_pulse);
      end
    end
    check("pulses_three_presses", pulses, 3);
    check("pulses_on_release", pulse_at, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
